digital_mod: RTL



---
 rtl/digital_mod.sv | 117 +++++++++++
 1 files changed

// File: rtl/digital_mod.sv
// rtl/digital_mod.sv - ASK/FSK/BPSK carrier modulator: PN symbol capture, phase accumulator, quarter-wave sine LUT
module digital_mod #(
  parameter int unsigned        PHASE_W = 24,
  parameter logic [PHASE_W-1:0] FCW0    = 24'd3355,
  parameter logic [PHASE_W-1:0] FCW1    = 24'd6711
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       bit_clk,
  input  logic       m_ser_in,
  input  logic [1:0] mode,
  output logic [7:0] dac_out,
  output logic       sym_strobe,
  output logic       data_bit
);

  localparam logic [1:0] MODE_ASK  = 2'b00;
  localparam logic [1:0] MODE_FSK  = 2'b01;
  localparam logic [1:0] MODE_BPSK = 2'b10;
  localparam logic [1:0] MODE_RSVD = 2'b11;

  logic               bclk_s1_q, bclk_s2_q, bclk_s3_q;
  logic               ser_s1_q, ser_s2_q;
  logic               bclk_fall;
  logic               data_bit_q, data_bit_d;
  logic [1:0]         mode_q, mode_d;
  logic               sym_strobe_q;
  logic [PHASE_W-1:0] acc_q, acc_d, fcw;
  logic [7:0]         addr_q, addr_d;
  logic               gate_q, gate_d;
  logic [7:0]         dac_q, dac_d;
  logic [5:0]         lut_idx;
  logic [6:0]         lut_val;

  function automatic logic [6:0] qsine(input logic [5:0] idx);
    case (idx)
      6'd0:  qsine = 7'd2;   6'd1:  qsine = 7'd5;   6'd2:  qsine = 7'd8;   6'd3:  qsine = 7'd11;
      6'd4:  qsine = 7'd14;  6'd5:  qsine = 7'd17;  6'd6:  qsine = 7'd20;  6'd7:  qsine = 7'd23;
      6'd8:  qsine = 7'd26;  6'd9:  qsine = 7'd29;  6'd10: qsine = 7'd32;  6'd11: qsine = 7'd35;
      6'd12: qsine = 7'd38;  6'd13: qsine = 7'd41;  6'd14: qsine = 7'd44;  6'd15: qsine = 7'd47;
      6'd16: qsine = 7'd50;  6'd17: qsine = 7'd53;  6'd18: qsine = 7'd56;  6'd19: qsine = 7'd58;
      6'd20: qsine = 7'd61;  6'd21: qsine = 7'd64;  6'd22: qsine = 7'd67;  6'd23: qsine = 7'd69;
      6'd24: qsine = 7'd72;  6'd25: qsine = 7'd74;  6'd26: qsine = 7'd77;  6'd27: qsine = 7'd79;
      6'd28: qsine = 7'd82;  6'd29: qsine = 7'd84;  6'd30: qsine = 7'd86;  6'd31: qsine = 7'd89;
      6'd32: qsine = 7'd91;  6'd33: qsine = 7'd93;  6'd34: qsine = 7'd95;  6'd35: qsine = 7'd97;
      6'd36: qsine = 7'd99;  6'd37: qsine = 7'd101; 6'd38: qsine = 7'd103; 6'd39: qsine = 7'd105;
      6'd40: qsine = 7'd106; 6'd41: qsine = 7'd108; 6'd42: qsine = 7'd110; 6'd43: qsine = 7'd111;
      6'd44: qsine = 7'd113; 6'd45: qsine = 7'd114; 6'd46: qsine = 7'd115; 6'd47: qsine = 7'd117;
      6'd48: qsine = 7'd118; 6'd49: qsine = 7'd119; 6'd50: qsine = 7'd120; 6'd51: qsine = 7'd121;
      6'd52: qsine = 7'd122; 6'd53: qsine = 7'd123; 6'd54: qsine = 7'd124; 6'd55: qsine = 7'd124;
      6'd56: qsine = 7'd125; 6'd57: qsine = 7'd125; 6'd58: qsine = 7'd126; 6'd59: qsine = 7'd126;
      default: qsine = 7'd127;
    endcase
  endfunction

  // Capture on the falling edge: mid-bit, well away from upstream data transitions.
  assign bclk_fall  = bclk_s3_q & ~bclk_s2_q;
  assign data_bit_d = bclk_fall ? ser_s2_q : data_bit_q;
  assign mode_d     = bclk_fall ? mode     : mode_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bclk_s1_q    <= 1'b0;
      bclk_s2_q    <= 1'b0;
      bclk_s3_q    <= 1'b0;
      ser_s1_q     <= 1'b0;
      ser_s2_q     <= 1'b0;
      sym_strobe_q <= 1'b0;
      data_bit_q   <= 1'b0;
      mode_q       <= MODE_ASK;
    end else begin
      bclk_s1_q    <= bit_clk;
      bclk_s2_q    <= bclk_s1_q;
      bclk_s3_q    <= bclk_s2_q;
      ser_s1_q     <= m_ser_in;
      ser_s2_q     <= ser_s1_q;
      sym_strobe_q <= bclk_fall;
      data_bit_q   <= data_bit_d;
      mode_q       <= mode_d;
    end
  end

  always_comb begin
    fcw     = (mode_q == MODE_FSK && data_bit_q) ? FCW1 : FCW0;
    acc_d   = acc_q + fcw;
    addr_d  = acc_q[PHASE_W-1 -: 8] + ((mode_q == MODE_BPSK && data_bit_q) ? 8'h80 : 8'h00);
    gate_d  = (mode_q == MODE_RSVD) || (mode_q == MODE_ASK && !data_bit_q);
    lut_idx = addr_q[6] ? ~addr_q[5:0] : addr_q[5:0];
    lut_val = qsine(lut_idx);
    if (gate_q)
      dac_d = 8'd128;
    else if (addr_q[7])
      dac_d = 8'd128 - {1'b0, lut_val};
    else
      dac_d = 8'd128 + {1'b0, lut_val};
  end

  // Accumulator is never cleared on symbol changes, keeping FSK phase-continuous.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_q  <= '0;
      addr_q <= 8'd0;
      gate_q <= 1'b1;
      dac_q  <= 8'd128;
    end else begin
      acc_q  <= acc_d;
      addr_q <= addr_d;
      gate_q <= gate_d;
      dac_q  <= dac_d;
    end
  end

  assign dac_out    = dac_q;
  assign sym_strobe = sym_strobe_q;
  assign data_bit   = data_bit_q;

endmodule
